// File: rtl/prog_fetch_unit.sv
// Instruction fetch stage: owns the PC, captures program-memory words for decode,
// and handles stalls, branch/jump redirects and sticky fetch faults.
module prog_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h00001030,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             stall,
   input  logic             branch_en,
   input  logic [31:0]      branch_target,
   input  logic             cs,
   input  logic [31:0]      mem_rdata,
   output logic [31:0]      address,
   output logic [31:0]      instr,
   output logic [31:0]      instr_pc,
   output logic             instr_valid,
   output logic             fault,
   output logic [CNT_W-1:0] fetch_count
);

   typedef enum logic [1:0] {StIdle, StFetch, StHold, StFault} state_e;

   state_e           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      instr_q, instr_d;
   logic [31:0]      instr_pc_q, instr_pc_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             misaligned;

   assign misaligned = (branch_target[1:0] != 2'b00);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      cnt_d      = cnt_q;
      valid_d    = 1'b0;
      unique case (state_q)
         StIdle: state_d = StFetch;
         StFetch: begin
            if (!cs) begin
               state_d = StFault;
            end else if (branch_en && misaligned) begin
               state_d = StFault;
            end else if (branch_en) begin
               // Word currently on the bus is discarded; fetch resumes at the target.
               pc_d = branch_target;
            end else if (stall) begin
               state_d = StHold;
            end else begin
               instr_d    = mem_rdata;
               instr_pc_d = pc_q;
               valid_d    = 1'b1;
               pc_d       = pc_q + 32'd4;
               cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         StHold: begin
            if (branch_en && misaligned) begin
               state_d = StFault;
            end else if (branch_en) begin
               pc_d    = branch_target;
               state_d = StFetch;
            end else if (!stall) begin
               // Re-present the held PC to memory; capture happens on the following edge.
               state_d = StFetch;
            end
         end
         StFault: state_d = StFault;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= StIdle;
         pc_q       <= RESET_PC;
         instr_q    <= 32'h0;
         instr_pc_q <= 32'h0;
         valid_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
         cnt_q      <= cnt_d;
      end
   end

   assign address     = pc_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = valid_q;
   assign fault       = (state_q == StFault);
   assign fetch_count = cnt_q;

endmodule

// File: tb/tb_prog_fetch_unit.sv
// Self-checking bench for prog_fetch_unit: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural reference model.
module tb_prog_fetch_unit;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        stall = 1'b0;
   logic        branch_en = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        cs;
   logic [31:0] mem_rdata;
   logic [31:0] address;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        fault;
   logic [15:0] fetch_count;
   logic        full_cs = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   prog_fetch_unit #(
      .RESET_PC(32'h00001030),
      .CNT_W   (16)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .stall        (stall),
      .branch_en    (branch_en),
      .branch_target(branch_target),
      .cs           (cs),
      .mem_rdata    (mem_rdata),
      .address      (address),
      .instr        (instr),
      .instr_pc     (instr_pc),
      .instr_valid  (instr_valid),
      .fault        (fault),
      .fetch_count  (fetch_count)
   );

   always #5 Clk = ~Clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
   endfunction

   function automatic logic in_window(input logic [31:0] a);
      return (a >= 32'h1030) && (a <= 32'h142F);
   endfunction

   assign cs        = full_cs | in_window(address);
   assign mem_rdata = mem_word(address);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic s, input logic be, input logic [31:0] tgt);
      stall         = s;
      branch_en     = be;
      branch_target = tgt;
      @(posedge Clk);
      #1;
   endtask

   task automatic check_reset_values();
      chk("rst_address", address, 32'h1030);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
      chk("rst_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst_fault", {31'h0, fault}, 32'h0);
      chk("rst_count", {16'h0, fetch_count}, 32'h0);
   endtask

   task automatic do_reset();
      stall     = 1'b0;
      branch_en = 1'b0;
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      check_reset_values();
      @(negedge Clk);
      Reset = 1'b1;
   endtask

   // Reference model: spec rules applied per edge on plain variables.
   int          m_phase;  // 0 settling, 1 fetching, 2 holding, 3 faulted
   logic [31:0] m_pc, m_ipc, m_instr;
   logic        m_valid;
   logic [15:0] m_cnt;

   task automatic model_reset();
      m_phase = 0; m_pc = 32'h1030; m_ipc = 0; m_instr = 0; m_valid = 0; m_cnt = 0;
   endtask

   task automatic model_edge(input logic s, input logic be, input logic [31:0] tgt);
      logic mis;
      mis     = (tgt % 4) != 0;
      m_valid = 1'b0;
      if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1) begin
         if (!(full_cs || in_window(m_pc))) m_phase = 3;
         else if (be && mis) m_phase = 3;
         else if (be) m_pc = tgt;
         else if (s) m_phase = 2;
         else begin
            m_instr = mem_word(m_pc);
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 4;
            m_cnt   = m_cnt + 1;
         end
      end else if (m_phase == 2) begin
         if (be && mis) m_phase = 3;
         else if (be) begin m_pc = tgt; m_phase = 1; end
         else if (!s) m_phase = 1;
      end
   endtask

   typedef struct {
      logic        st;
      logic        be;
      logic [31:0] tgt;
      logic        ev;
      logic [31:0] eipc;
      logic [31:0] eaddr;
      logic        ef;
      logic [15:0] ecnt;
   } vec_t;

   vec_t vecs[14];

   initial begin
      vecs[0]  = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    32'h1030, 1'b0, 16'd0};
      vecs[1]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h1030, 32'h1034, 1'b0, 16'd1};
      vecs[2]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h1034, 32'h1038, 1'b0, 16'd2};
      vecs[3]  = '{1'b1, 1'b0, 32'h0,    1'b0, 32'h1034, 32'h1038, 1'b0, 16'd2};
      vecs[4]  = '{1'b1, 1'b0, 32'h0,    1'b0, 32'h1034, 32'h1038, 1'b0, 16'd2};
      vecs[5]  = '{1'b1, 1'b0, 32'h0,    1'b0, 32'h1034, 32'h1038, 1'b0, 16'd2};
      vecs[6]  = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h1034, 32'h1038, 1'b0, 16'd2};
      vecs[7]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h1038, 32'h103C, 1'b0, 16'd3};
      vecs[8]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h103C, 32'h1040, 1'b0, 16'd4};
      vecs[9]  = '{1'b0, 1'b1, 32'h1130, 1'b0, 32'h103C, 32'h1130, 1'b0, 16'd4};
      vecs[10] = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h1130, 32'h1134, 1'b0, 16'd5};
      vecs[11] = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h1134, 32'h1138, 1'b0, 16'd6};
      vecs[12] = '{1'b0, 1'b1, 32'h1132, 1'b0, 32'h1134, 32'h1138, 1'b1, 16'd6};
      vecs[13] = '{1'b0, 1'b1, 32'h1030, 1'b0, 32'h1134, 32'h1138, 1'b1, 16'd6};

      // Directed table: fetch, stall/recover, branch, misaligned branch, fault stickiness.
      do_reset();
      for (int i = 0; i < 14; i++) begin
         step(vecs[i].st, vecs[i].be, vecs[i].tgt);
         chk($sformatf("tbl%0d_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].ev});
         chk($sformatf("tbl%0d_instr_pc", i), instr_pc, vecs[i].eipc);
         chk($sformatf("tbl%0d_address", i), address, vecs[i].eaddr);
         chk($sformatf("tbl%0d_fault", i), {31'h0, fault}, {31'h0, vecs[i].ef});
         chk($sformatf("tbl%0d_count", i), {16'h0, fetch_count}, {16'h0, vecs[i].ecnt});
         if (vecs[i].ev) chk($sformatf("tbl%0d_instr", i), instr, mem_word(vecs[i].eipc));
      end

      // Run off the end of the decoder window.
      do_reset();
      begin
         int n = 0;
         while (address != 32'h1430 && n < 400) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
         end
         chk("win_reached", address, 32'h1430);
      end
      chk("win_last_pc", instr_pc, 32'h142C);
      chk("win_last_valid", {31'h0, instr_valid}, 32'h1);
      chk("win_count", {16'h0, fetch_count}, 32'd256);
      step(1'b0, 1'b0, 32'h0);
      chk("win_fault", {31'h0, fault}, 32'h1);
      chk("win_fault_addr", address, 32'h1430);
      chk("win_fault_valid", {31'h0, instr_valid}, 32'h0);
      step(1'b0, 1'b1, 32'h1030);
      chk("win_br_ignored_addr", address, 32'h1430);
      chk("win_br_ignored_valid", {31'h0, instr_valid}, 32'h0);
      chk("win_br_count", {16'h0, fetch_count}, 32'd256);

      // Asynchronous reset in the middle of a stall.
      do_reset();
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      #2 Reset = 1'b0;
      #1 check_reset_values();
      @(negedge Clk);
      Reset = 1'b1;
      step(1'b0, 1'b0, 32'h0);
      chk("rel_edge1_valid", {31'h0, instr_valid}, 32'h0);
      chk("rel_edge1_addr", address, 32'h1030);
      step(1'b0, 1'b0, 32'h0);
      chk("rel_edge2_valid", {31'h0, instr_valid}, 32'h1);
      chk("rel_edge2_pc", instr_pc, 32'h1030);

      // Randomized run against the reference model.
      do_reset();
      model_reset();
      for (int i = 0; i < 600; i++) begin
         logic        s, be;
         logic [31:0] tgt;
         if (m_phase == 3 && $urandom_range(0, 3) == 0) begin
            do_reset();
            model_reset();
         end
         s   = ($urandom_range(0, 3) == 0);
         be  = ($urandom_range(0, 7) == 0);
         tgt = ($urandom_range(0, 24) == 0) ? 32'h1030 + $urandom_range(0, 1023)
                                            : 32'h1030 + 4 * $urandom_range(0, 255);
         model_edge(s, be, tgt);
         step(s, be, tgt);
         chk("rnd_address", address, m_pc);
         chk("rnd_valid", {31'h0, instr_valid}, {31'h0, m_valid});
         chk("rnd_instr_pc", instr_pc, m_ipc);
         chk("rnd_instr", instr, m_instr);
         chk("rnd_fault", {31'h0, fault}, {31'h0, m_phase == 3});
         chk("rnd_count", {16'h0, fetch_count}, {16'h0, m_cnt});
      end

      // Counter wrap with the decoder selecting everything.
      full_cs = 1'b1;
      do_reset();
      stall     = 1'b0;
      branch_en = 1'b0;
      repeat (65536) @(posedge Clk);
      #1;
      chk("wrap_pre_count", {16'h0, fetch_count}, 32'h0000FFFF);
      step(1'b0, 1'b0, 32'h0);
      chk("wrap_count", {16'h0, fetch_count}, 32'h0);
      chk("wrap_valid", {31'h0, instr_valid}, 32'h1);
      chk("wrap_pc", instr_pc, 32'h0004102C);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/prog_fetch_unit.md
# prog_fetch_unit

Instruction fetch stage of the MIPS CPU. It holds the program counter and drives `address` to the program-memory address decoder, which returns `cs`. It captures the instruction word from program memory and hands it, with its PC, to decode. Stalls, branch/jump redirects and out-of-window or misaligned fetches (which produce a sticky fault) are all handled here.

## Interface
- `RESET_PC`, 32'h00001030: PC loaded on reset; first fetch address.
- `CNT_W`, 16: width of the delivered-instruction counter.

- `Clk`  input  1  system clock; all state updates on the rising edge.
- `Reset`  input  1  asynchronous, active-low reset.
- `stall`  input  1  downstream not ready; hold PC and outputs.
- `branch_en`  input  1  redirect request, valid for one cycle.
- `branch_target`  input  32  redirect PC; must be word-aligned.
- `cs`  input  1  chip select from the program-memory address decoder for the current `address`; combinational in the same cycle.
- `mem_rdata`  input  32  instruction word; combinational read, valid in the same cycle as `address` when `cs`=1.
- `address`  output  32  current PC, driven directly from the PC register.
- `instr`  output  32  registered instruction word.
- `instr_pc`  output  32  PC of `instr`.
- `instr_valid`  output  1  `instr`/`instr_pc` hold a new instruction this cycle.
- `fault`  output  1  sticky fetch fault.
- `fetch_count`  output  CNT_W  number of instructions delivered; wraps modulo 2^CNT_W.

## Operation
- States: IDLE, FETCH, HOLD, FAULT.
- **Reset** (asynchronous, while `Reset`=0):
  - PC=`RESET_PC`, state=IDLE.
  - `instr`=0, `instr_pc`=0, `instr_valid`=0, `fault`=0, `fetch_count`=0.
  - `address`=`RESET_PC`.
- **IDLE**: one settling cycle; goes to FETCH on the first edge after reset release. No capture.
- **FETCH**, at each edge, in priority order:
  1. `cs`=0: go to FAULT. Set `fault`=1, `instr_valid`=0; PC is unchanged.
  2. `branch_en`=1 and `branch_target[1:0]`≠0: go to FAULT. Set `fault`=1, `instr_valid`=0; PC is unchanged.
  3. `branch_en`=1 (aligned): PC=`branch_target`, `instr_valid`=0, stay in FETCH. The current word is discarded.
  4. `stall`=1: go to HOLD. PC, `instr`, `instr_pc` and `fetch_count` hold; `instr_valid`=0.
  5. Otherwise:
     - `instr`=`mem_rdata`, `instr_pc`=PC, `instr_valid`=1.
     - PC=PC+4, modulo 2^32 (0xFFFFFFFC wraps to 0).
     - `fetch_count`+1.
- **HOLD**:
  - `branch_en`=1: aligned target → PC=target and go to FETCH; misaligned → FAULT.
  - Else `stall`=1: stay in HOLD.
  - Else go to FETCH and refetch the same PC; no capture on this edge.
  - `instr_valid`=0 throughout.
- **FAULT**:
  - Terminal until `Reset`.
  - `fault`=1, `instr_valid`=0.
  - `address` holds the faulting PC.
  - `branch_en` and `stall` are ignored.
  - `cs` is not checked.
- `fetch_count` increments only on edges where `instr_valid` is set to 1.

## Timing
- `address` changes only on clock edges (or asynchronously on reset).
- Fetch latency: `address`=A in cycle N with `cs`=1 and no stall or branch → `instr`=mem[A], `instr_pc`=A, `instr_valid`=1 in cycle N+1.
- Throughput: one instruction per cycle while in FETCH.
- Stall recovery:
  - An edge that sees `stall`=1 moves to HOLD.
  - The first edge in HOLD that sees `stall`=0 returns to FETCH.
  - The next edge captures.
- Branch: `branch_en` sampled at edge N → `address`=target from N+1; first instruction from the target is valid at N+2.
- `instr_valid` is a one-cycle pulse per instruction. It is never high in two consecutive cycles for the same `instr_pc`.
- Reset asserted mid-fetch or mid-stall: outputs return to reset values immediately. The first fetch after release occurs two edges after release (IDLE, then FETCH).

## Test plan
- Reset with `RESET_PC`=0x1030 and a decoder model asserting `cs` for 0x1030–0x142F → `address`=0x1030; after release `instr_valid` pulses with `instr_pc`=0x1030, 0x1034, 0x1038; `fetch_count`=3.
- `stall` high for 3 cycles after `instr_pc`=0x1034 → no `instr_valid`, `address` frozen at 0x1038; next valid `instr_pc`=0x1038; `fetch_count` counts no duplicates.
- `branch_en` with target 0x1130 while `address`=0x1040 → word at 0x1040 is dropped; next valid `instr_pc`=0x1130, then 0x1134.
- Sequential run to 0x142C, then `address`=0x1430 gets `cs`=0 → `fault`=1 one edge later; `address` stays 0x1430; no further `instr_valid` even with `branch_en` to 0x1030.
- Branch to 0x1132 (misaligned) → FAULT; `address` stays at the pre-branch PC; `fault`=1.
- `Reset` pulsed low mid-HOLD, and `fetch_count` preset near 0xFFFF with CNT_W=16 → immediate return to reset values; separately, counter wraps 0xFFFF→0x0000 on the next delivered instruction.
